c1541_sd_arbiter: RTL and testbench
===================================

# c1541_sd_arbiter

Shares the single host SD sector channel (LBA, read/write strobes, ack, 512-byte buffer port) between up to four track-buffer requesters, e.g. two drive track loaders. It runs in the sd_clk domain between the host block-I/O interface and the requesters' SD-side ports. Each requester issues one sector transfer at a time as a level request. The arbiter grants round-robin, holds the grant for the whole ack window, and steers ack, buffer writes and read-back data to the granted requester only.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- TIMEOUT, 24'd12_000_000, sd_clk cycles allowed from strobe to sd_ack rise (used only with the macro)

Ports:
- sd_clk  in  1  clock for all logic
- reset  in  1  synchronous, active-high; clock sd_clk
- req_lba  in  NREQ*32  sector address per requester, slice i = [32*i+31:32*i]
- req_rd  in  NREQ  read request levels
- req_wr  in  NREQ  write request levels
- req_ack  out  NREQ  sd_ack routed to the granted requester, 0 elsewhere
- req_err  out  NREQ  one-cycle timeout pulse
- req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester
- req_buff_din  in  NREQ*8  per-requester buffer read data
- grant  out  NREQ  one-hot current owner, 0 when idle
- busy  out  1  |grant
- sd_lba  out  32  latched LBA of the owner
- sd_rd, sd_wr  out  1  host strobes
- sd_ack  in  1  host acknowledge
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  8  req_buff_din slice of the owner, 0 when idle

sd_buff_addr and sd_buff_dout are broadcast outside this block.

## Operation
- States: IDLE, ISSUE, XFER, RELEASE. Reset: IDLE, grant=0, sd_rd=sd_wr=0, sd_lba=0, req_err=0, rr pointer=NREQ-1.
- IDLE: a grant is made only when sd_ack=0. Candidates are i with req_rd[i]|req_wr[i]. Search order starts at rr+1 mod NREQ. On a pick: latch sd_lba and direction, set grant and rr=i, assert sd_wr if req_wr[i] else sd_rd, go to ISSUE.
  - If a requester asserts rd and wr together, wr wins.
- ISSUE: hold the strobe. When sd_ack=1 is sampled, deassert the strobe and go to XFER.
- XFER: req_ack[owner]=sd_ack; req_buff_wr[owner]=sd_buff_wr. When sd_ack=0 is sampled, go to RELEASE.
- RELEASE: one cycle with grant cleared. This gives the requester time to drop or renew its request. Then go to IDLE.
- Request changes after grant are ignored; the LBA and direction stay latched until RELEASE.
- sd_buff_din is a combinational mux, adding no latency, so the requester's one-cycle RAM read latency is preserved.
- Reset mid-transfer: everything clears immediately. An sd_ack still high is not routed, and IDLE waits until it falls.

## Timing
- Request sampled at edge k in IDLE: grant and strobe are visible after edge k+1.
- sd_ack rise sampled at edge m: strobe low after m+1. req_ack follows sd_ack combinationally while granted.
- sd_ack fall sampled at edge n: RELEASE after n+1, IDLE after n+2. Earliest next strobe is after n+3.
- Back-to-back fairness: with all requesters active, grants rotate 0,1,..,NREQ-1,0.

## Configuration
- Macro: C1541_SD_ARB_TIMEOUT_EN.
- Defined: a 24-bit counter clears on entry to ISSUE and increments each ISSUE cycle. When it reaches TIMEOUT-1 with no ack:
  - sd_rd and sd_wr drop;
  - req_err[owner] pulses for 1 cycle;
  - state goes to RELEASE.
- Not defined: no counter; ISSUE waits indefinitely; req_err is constant 0.

## Test plan
- Single read: req_rd[0]=1, req_lba slice0=0x00000123. Required: sd_rd=1 and sd_lba=0x123 one cycle later. Ack is held 5 cycles with sd_buff_wr pulses; req_buff_wr[0] mirrors them, req_buff_wr[1]=0, and grant returns to 0 two cycles after the ack falls.
- Contention: req_rd[0] and req_wr[1] rise on the same edge after reset, with rr=1. Required: grant=01 first with sd_rd. After RELEASE, grant=10 with sd_wr, then back to requester 0.
- Write read-back: grant requester 1 for a write with req_buff_din slice1=0xA5 and slice0=0x3C. Required: sd_buff_din=0xA5 during XFER and 0x00 in IDLE.
- Reset mid-XFER with sd_ack=1 and a pending req_rd[1]. Required: all outputs are 0 the cycle after reset. No grant is made until sd_ack has been low for one sampled cycle.
- Timeout, with the macro defined and TIMEOUT=16: issue a read that is never acked. Required: sd_rd drops after 16 ISSUE cycles, req_err[0] is high for exactly 1 cycle, and grant=0 two cycles later. With the macro undefined, sd_rd stays high indefinitely.
- rd+wr together on requester 0: sd_wr=1 and sd_rd=0.

Source files
------------

// File: rtl/c1541_sd_arbiter_if.sv
// ---------------------------------------------------------------------------
// c1541_sd_arbiter_if
//
// Bundles the requester-side and host-side signals of the SD sector channel
// arbiter so that both ends can be connected with a single port.
//
// Parameter:
//   NREQ          number of requesters (2..4)
//
// Signals:
//   req_lba       NREQ*32  sector address per requester (slice i = [32*i+31:32*i])
//   req_rd/wr     NREQ     read / write request levels
//   req_ack       NREQ     host ack routed to the current owner
//   req_err       NREQ     one-cycle timeout pulse to the owner
//   req_buff_wr   NREQ     host buffer write strobe routed to the owner
//   req_buff_din  NREQ*8   per-requester buffer read data
//   grant         NREQ     one-hot current owner, 0 when idle
//   busy          1        any grant active
//   sd_lba        32       latched LBA of the owner
//   sd_rd/sd_wr   1        host read / write strobes
//   sd_ack        1        host acknowledge
//   sd_buff_wr    1        host buffer write strobe
//   sd_buff_din   8        owner's buffer read data, 0 when idle
//
// Modports:
//   master        arbiter side (drives the host strobes and requester returns)
//   slave         environment side (requesters plus host block-I/O)
// ---------------------------------------------------------------------------
interface c1541_sd_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ*32-1:0] req_lba;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_err;
    logic [NREQ-1:0]    req_buff_wr;
    logic [NREQ*8-1:0]  req_buff_din;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack;
    logic               sd_buff_wr;
    logic [7:0]         sd_buff_din;

    modport master (
        input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        output req_ack, req_err, req_buff_wr, grant, busy,
               sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        input  req_ack, req_err, req_buff_wr, grant, busy,
               sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/c1541_sd_arbiter.sv
// ---------------------------------------------------------------------------
// c1541_sd_arbiter
//
// Shares the single host SD sector channel between NREQ track-buffer
// requesters. Grants round-robin, holds the grant for the whole ack window,
// and steers ack, buffer writes and read-back data to the owner only.
//
// Ports:
//   sd_clk   clock for all logic
//   reset    synchronous, active-high
//   bus      c1541_sd_arbiter_if.master (requester and host signals)
//
// Parameters:
//   NREQ     number of requesters (2..4)
//   TIMEOUT  sd_clk cycles allowed in ISSUE before giving up
//
// Optional feature:
//   C1541_SD_ARB_TIMEOUT_EN  when defined, an ISSUE watchdog drops the strobe
//                            after TIMEOUT cycles without ack, pulses
//                            req_err[owner] and releases the channel. When
//                            undefined, ISSUE waits indefinitely and req_err
//                            is constant 0.
// ---------------------------------------------------------------------------
module c1541_sd_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input logic                 sd_clk,
    input logic                 reset,
    c1541_sd_arbiter_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   rr_reg, rr_next;
    logic [31:0]     lba_reg, lba_next;
    logic            rd_reg, rd_next;
    logic            wr_reg, wr_next;

    logic [NREQ-1:0] cand;
    logic [31:0]     lba_arr [NREQ];
    logic [7:0]      din_arr [NREQ];
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;

`ifdef C1541_SD_ARB_TIMEOUT_EN
    logic [23:0]     cnt_reg, cnt_next;
    logic [NREQ-1:0] err_reg, err_next;
`endif

    // Per-requester slicing and owner-gated return paths.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign cand[gi]            = bus.req_rd[gi] | bus.req_wr[gi];
        assign lba_arr[gi]         = bus.req_lba[32*gi +: 32];
        assign din_arr[gi]         = bus.req_buff_din[8*gi +: 8];
        assign bus.req_ack[gi]     = grant_reg[gi] & bus.sd_ack;
        assign bus.req_buff_wr[gi] = grant_reg[gi] & bus.sd_buff_wr;
    end

    assign bus.grant  = grant_reg;
    assign bus.busy   = |grant_reg;
    assign bus.sd_lba = lba_reg;
    assign bus.sd_rd  = rd_reg;
    assign bus.sd_wr  = wr_reg;
    // Pure mux so the requester's registered RAM read latency is unchanged.
    assign bus.sd_buff_din = (|grant_reg) ? din_arr[owner_reg] : 8'h00;

`ifdef C1541_SD_ARB_TIMEOUT_EN
    assign bus.req_err = err_reg;
`else
    assign bus.req_err = '0;
    // TIMEOUT only matters when the watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            rr_reg    <= IW'(NREQ - 1);
            lba_reg   <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
`ifdef C1541_SD_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
            err_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            lba_reg   <= lba_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
`ifdef C1541_SD_ARB_TIMEOUT_EN
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        lba_next   = lba_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        found      = 1'b0;
        pick       = '0;
        idx        = '0;
`ifdef C1541_SD_ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
        err_next   = '0;
`endif

        // Round-robin scan beginning just after the last owner.
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_reg) + 1 + k) % NREQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_reg)
            IDLE: begin
                // A stale ack (e.g. after reset mid-transfer) must fall first.
                if (!bus.sd_ack && found) begin
                    grant_next       = '0;
                    grant_next[pick] = 1'b1;
                    owner_next       = pick;
                    rr_next          = pick;
                    lba_next         = lba_arr[pick];
                    wr_next          = bus.req_wr[pick];
                    rd_next          = ~bus.req_wr[pick];
                    state_next       = ISSUE;
`ifdef C1541_SD_ARB_TIMEOUT_EN
                    cnt_next         = '0;
`endif
                end
            end
            ISSUE: begin
                if (bus.sd_ack) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    state_next = XFER;
                end
`ifdef C1541_SD_ARB_TIMEOUT_EN
                else if (cnt_reg == TIMEOUT - 24'd1) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    err_next   = grant_reg;
                    grant_next = '0;
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt_reg + 24'd1;
                end
`endif
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    grant_next = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_c1541_sd_arbiter
//
// Directed scenarios for the sector arbiter plus a randomized run checked
// against a transaction-level round-robin model. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_c1541_sd_arbiter;
    localparam int NREQ = 2;

    logic sd_clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    c1541_sd_arbiter_if #(.NREQ(NREQ)) bus ();

    c1541_sd_arbiter #(.NREQ(NREQ), .TIMEOUT(24'd16)) dut (
        .sd_clk (sd_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sd_clk = ~sd_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.req_lba      = '0;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_buff_din = '0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ack for one cycle, drop it, and walk through RELEASE into IDLE.
    task automatic finish_xfer();
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL release_grant: got %b want 00", bus.grant);
        end
        tick();
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.req_lba      = '0;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_buff_din = '0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.grant, bus.busy, bus.sd_rd, bus.sd_wr, bus.req_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b busy=%b rd=%b wr=%b err=%b want all 0",
                     bus.grant, bus.busy, bus.sd_rd, bus.sd_wr, bus.req_err);
        end
        checks++;
        if (bus.sd_lba !== 32'd0 || bus.sd_buff_din !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got lba=%h din=%h want 0", bus.sd_lba, bus.sd_buff_din);
        end
        reset = 1'b0;
        $display("txn reset: done");
    endtask

    task automatic test_single_read();
        bus.req_lba[31:0] = 32'h0000_0123;
        bus.req_rd        = 2'b01;
        tick();
        checks++;
        if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL single_issue: got rd=%b wr=%b grant=%b want 1 0 01",
                     bus.sd_rd, bus.sd_wr, bus.grant);
        end
        checks++;
        if (bus.sd_lba !== 32'h123) begin
            errors++;
            $display("FAIL single_lba: got %h want 00000123", bus.sd_lba);
        end
        bus.sd_ack = 1'b1;
        tick();
        checks++;
        if (bus.sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_strobe_drop: got %b want 0", bus.sd_rd);
        end
        for (int c = 0; c < 5; c++) begin
            bus.sd_buff_wr = c[0];
            #1;
            checks++;
            if (bus.req_buff_wr !== {1'b0, c[0]} || bus.req_ack !== 2'b01) begin
                errors++;
                $display("FAIL single_route: got buff_wr=%b ack=%b want %b 01",
                         bus.req_buff_wr, bus.req_ack, {1'b0, c[0]});
            end
            tick();
        end
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b0;
        bus.req_rd     = 2'b00;
        tick();
        tick();
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got grant=%b busy=%b want 00 0", bus.grant, bus.busy);
        end
        $display("txn single_read: lba=%h", 32'h123);
    endtask

    task automatic test_contention();
        do_reset();
        bus.req_rd = 2'b01;
        bus.req_wr = 2'b10;
        tick();
        checks++;
        if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0) begin
            errors++;
            $display("FAIL contention_first: got grant=%b rd=%b wr=%b want 01 1 0",
                     bus.grant, bus.sd_rd, bus.sd_wr);
        end
        finish_xfer();
        tick();
        checks++;
        if (bus.grant !== 2'b10 || bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL contention_second: got grant=%b rd=%b wr=%b want 10 0 1",
                     bus.grant, bus.sd_rd, bus.sd_wr);
        end
        finish_xfer();
        tick();
        checks++;
        if (bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL contention_third: got grant=%b want 01", bus.grant);
        end
        bus.req_rd = 2'b00;
        bus.req_wr = 2'b00;
        finish_xfer();
        $display("txn contention: grants 01,10,01");
    endtask

    task automatic test_readback();
        do_reset();
        bus.req_buff_din = {8'hA5, 8'h3C};
        bus.req_wr       = 2'b10;
        tick();
        bus.req_wr = 2'b00;
        bus.sd_ack = 1'b1;
        tick();
        checks++;
        if (bus.sd_buff_din !== 8'hA5) begin
            errors++;
            $display("FAIL readback_xfer: got %h want a5", bus.sd_buff_din);
        end
        bus.sd_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.sd_buff_din !== 8'h00) begin
            errors++;
            $display("FAIL readback_idle: got %h want 00", bus.sd_buff_din);
        end
        $display("txn readback: owner=1");
    endtask

    task automatic test_rd_wr_both();
        bus.req_rd = 2'b01;
        bus.req_wr = 2'b01;
        tick();
        checks++;
        if (bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL rdwr_both: got rd=%b wr=%b grant=%b want 0 1 01",
                     bus.sd_rd, bus.sd_wr, bus.grant);
        end
        bus.req_rd = 2'b00;
        bus.req_wr = 2'b00;
        finish_xfer();
        $display("txn rd_wr_both: write wins");
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        bus.req_lba[31:0] = 32'hDEAD_0042;
        bus.req_rd        = 2'b01;
        tick();
        bus.sd_ack = 1'b1;
        tick();
        bus.req_rd     = 2'b10;
        bus.sd_buff_wr = 1'b1;
        reset          = 1'b1;
        tick();
        checks++;
        if ({bus.grant, bus.req_ack, bus.req_buff_wr, bus.sd_rd, bus.sd_wr, bus.busy} !== 9'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got grant=%b ack=%b bwr=%b rd=%b wr=%b busy=%b want 0",
                     bus.grant, bus.req_ack, bus.req_buff_wr, bus.sd_rd, bus.sd_wr, bus.busy);
        end
        checks++;
        if (bus.sd_lba !== 32'd0 || bus.sd_buff_din !== 8'd0) begin
            errors++;
            $display("FAIL midreset_data: got lba=%h din=%h want 0", bus.sd_lba, bus.sd_buff_din);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.grant !== 2'b00 || bus.req_ack !== 2'b00) begin
            errors++;
            $display("FAIL midreset_wait: got grant=%b ack=%b want 00 00", bus.grant, bus.req_ack);
        end
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 2'b10 || bus.sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL midreset_regrant: got grant=%b rd=%b want 10 1", bus.grant, bus.sd_rd);
        end
        bus.req_rd = 2'b00;
        finish_xfer();
        $display("txn reset_mid_xfer: done");
    endtask

    task automatic test_timeout();
        int cycles;
        bus.req_rd = 2'b01;
        tick();
        bus.req_rd = 2'b00;
`ifdef C1541_SD_ARB_TIMEOUT_EN
        cycles = 0;
        while (bus.sd_rd === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles !== 16) begin
            errors++;
            $display("FAIL timeout_len: got %0d strobe cycles want 16", cycles);
        end
        checks++;
        if (bus.req_err !== 2'b01 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL timeout_err: got err=%b grant=%b want 01 00", bus.req_err, bus.grant);
        end
        tick();
        checks++;
        if (bus.req_err !== 2'b00 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b grant=%b want 00 00", bus.req_err, bus.grant);
        end
        tick();
        $display("txn timeout: strobe cycles=%0d", cycles);
`else
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.sd_rd === 1'b1 && bus.req_err === 2'b00) cycles++;
        end
        checks++;
        if (cycles !== 40) begin
            errors++;
            $display("FAIL no_timeout_hold: got %0d cycles want 40", cycles);
        end
        finish_xfer();
        $display("txn no_timeout: strobe held %0d cycles", cycles);
`endif
    endtask

    // Model: each transaction goes to the first active requester found when
    // scanning from (last owner + 1) around the ring; write wins over read.
    task automatic test_random();
        int              rr_m;
        int              w;
        int              dly;
        int              len;
        logic            bw;
        logic [NREQ-1:0] rd;
        logic [NREQ-1:0] wr;
        logic [NREQ-1:0] act;
        logic [NREQ-1:0] eg;
        logic [31:0]     lba [NREQ];
        logic [7:0]      din [NREQ];
        do_reset();
        rr_m = NREQ - 1;
        for (int t = 0; t < 40; t++) begin
            rd = NREQ'($urandom);
            wr = NREQ'($urandom);
            if ((rd | wr) == '0) rd[$urandom_range(NREQ - 1)] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                lba[i] = $urandom;
                din[i] = 8'($urandom);
                bus.req_lba[32*i +: 32]     = lba[i];
                bus.req_buff_din[8*i +: 8]  = din[i];
            end
            bus.req_rd = rd;
            bus.req_wr = wr;
            act = rd | wr;
            w   = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (rr_m + 1 + k) % NREQ;
                if (w < 0 && act[c]) w = c;
            end
            rr_m  = w;
            eg    = '0;
            eg[w] = 1'b1;
            tick();
            checks++;
            if (bus.grant !== eg || {bus.sd_wr, bus.sd_rd} !== {wr[w], ~wr[w]} || bus.sd_lba !== lba[w]) begin
                errors++;
                $display("FAIL rand_grant t=%0d: got grant=%b wr/rd=%b%b lba=%h want %b %b%b %h",
                         t, bus.grant, bus.sd_wr, bus.sd_rd, bus.sd_lba, eg, wr[w], ~wr[w], lba[w]);
            end
            // Request changes after the grant must be ignored.
            bus.req_rd = NREQ'($urandom);
            bus.req_wr = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) bus.req_lba[32*i +: 32] = $urandom;
            dly = $urandom_range(3);
            repeat (dly) tick();
            checks++;
            if (bus.sd_lba !== lba[w] || {bus.sd_wr, bus.sd_rd} !== {wr[w], ~wr[w]}) begin
                errors++;
                $display("FAIL rand_latched t=%0d: got lba=%h wr/rd=%b%b want %h %b%b",
                         t, bus.sd_lba, bus.sd_wr, bus.sd_rd, lba[w], wr[w], ~wr[w]);
            end
            bus.sd_ack = 1'b1;
            #1;
            checks++;
            if (bus.req_ack !== eg) begin
                errors++;
                $display("FAIL rand_ack t=%0d: got %b want %b", t, bus.req_ack, eg);
            end
            tick();
            checks++;
            if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0 || bus.grant !== eg) begin
                errors++;
                $display("FAIL rand_xfer t=%0d: got rd=%b wr=%b grant=%b want 0 0 %b",
                         t, bus.sd_rd, bus.sd_wr, bus.grant, eg);
            end
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                bw             = 1'($urandom);
                bus.sd_buff_wr = bw;
                #1;
                checks++;
                if (bus.req_buff_wr !== (bw ? eg : '0) || bus.sd_buff_din !== din[w]) begin
                    errors++;
                    $display("FAIL rand_data t=%0d: got bwr=%b din=%h want %b %h",
                             t, bus.req_buff_wr, bus.sd_buff_din, (bw ? eg : '0), din[w]);
                end
                tick();
            end
            bus.sd_buff_wr = 1'b0;
            bus.sd_ack     = 1'b0;
            tick();
            checks++;
            if (bus.grant !== '0 || bus.req_ack !== '0) begin
                errors++;
                $display("FAIL rand_release t=%0d: got grant=%b ack=%b want 0", t, bus.grant, bus.req_ack);
            end
            tick();
            $display("txn %0d: owner=%0d dir=%s lba=%h bytes=%0d", t, w, wr[w] ? "wr" : "rd", lba[w], len);
        end
        bus.req_rd = '0;
        bus.req_wr = '0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_contention();
        test_readback();
        test_rd_wr_both();
        test_reset_mid_xfer();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
